baseline_ema_tracker_par: RTL and testbench

- Parametrised, lane-parallel baseline estimator and remover for the multi-sample-per-clock ADC path.
- Lightweight companion to the wavelet baseline remover: fixed 3-cycle latency instead of ~155.
- Exponential-moving-average tracking with pulse-gated hold and holdoff, a fast initial acquisition phase, and a runtime bypass.
- Sits between the ADC lane unpacker and the pulse processing chain.

---
 rtl/baseline_ema_tracker_par.sv | 169 ++++++++++++++++
 tb/tb_baseline_ema_tracker_par.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baseline_ema_tracker_par.sv
// Lane-parallel EMA baseline tracker/remover: 3-stage pipeline, acquisition,
// pulse-gated hold with holdoff, and per-block bypass.
module baseline_ema_tracker_par #(
  parameter int DATA_WIDTH  = 16,
  parameter int LANES       = 16,
  parameter int DATA_OUTPUT = 17,
  parameter int EMA_SHIFT   = 4,
  parameter int HOLDOFF     = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         din_valid,
  input  logic [DATA_WIDTH*LANES-1:0]  din,
  input  logic [DATA_WIDTH-1:0]        thresh,
  input  logic                         bypass,
  output logic                         baseline_valid,
  output logic [DATA_OUTPUT*LANES-1:0] baseline,
  output logic [DATA_OUTPUT*LANES-1:0] signal_no_baseline,
  output logic                         pulse_flag,
  output logic                         locked
);

  localparam int LG    = $clog2(LANES);
  localparam int SUM_W = DATA_WIDTH + LG;
  localparam int ACC_W = DATA_WIDTH + EMA_SHIFT + 1;
  localparam int CMP_W = DATA_WIDTH + 2;
  localparam int CNT_W = EMA_SHIFT + 1;
  localparam int HO_W  = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {ACQ = 2'd0, TRACK = 2'd1, HOLD = 2'd2} state_e;

  state_e                        state_q, state_d;
  logic [DATA_WIDTH*LANES-1:0]   din1_q, din2_q;
  logic                          vld1_q, byp1_q, vld2_q, byp2_q;
  logic signed [SUM_W-1:0]       sum_d, sum_q;
  logic                          pulse_d, pulse_q;
  logic signed [ACC_W-1:0]       acc_d, acc_q;
  logic [CNT_W-1:0]              cnt_d, cnt_q;
  logic [HO_W-1:0]               ho_d, ho_q;
  logic signed [DATA_WIDTH-1:0]  bl_q, bl_d, mean;
  logic signed [CMP_W-1:0]       thr_s;
  logic signed [DATA_OUTPUT-1:0] bl_out;
  logic [DATA_OUTPUT*LANES-1:0]  base_d, sig_d, base_q, sig_q;
  logic                          bv_q, pf_q;

  assign bl_q  = DATA_WIDTH'(acc_q >>> EMA_SHIFT);
  assign bl_d  = DATA_WIDTH'(acc_d >>> EMA_SHIFT);
  assign mean  = DATA_WIDTH'(sum_q >>> LG);
  assign thr_s = signed'(CMP_W'(thresh));

  // S1 input capture, S2 block sum and pulse decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q  <= 1'b0;
      byp1_q  <= 1'b0;
      din1_q  <= '0;
      vld2_q  <= 1'b0;
      byp2_q  <= 1'b0;
      din2_q  <= '0;
      sum_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      vld1_q  <= din_valid;
      byp1_q  <= bypass;
      din1_q  <= din;
      vld2_q  <= vld1_q;
      byp2_q  <= byp1_q;
      din2_q  <= din1_q;
      sum_q   <= sum_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < LANES; i++)
      sum_d = sum_d + SUM_W'(signed'(din1_q[i*DATA_WIDTH +: DATA_WIDTH]));
  end

  // Compare against the estimator as it will stand once the block ahead in
  // S2 has been applied, so each block sees the baseline of all prior blocks.
  always_comb begin
    pulse_d = 1'b0;
    if (!byp1_q && state_d != ACQ) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if ((CMP_W'(signed'(din1_q[i*DATA_WIDTH +: DATA_WIDTH])) - CMP_W'(bl_d)) > thr_s)
          pulse_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ho_d    = ho_q;
    if (vld2_q && !byp2_q) begin
      case (state_q)
        ACQ: begin
          acc_d = acc_q + ACC_W'(mean);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'((1 << EMA_SHIFT) - 1))
            state_d = TRACK;
        end
        TRACK: begin
          if (pulse_q) begin
            ho_d    = HO_W'(HOLDOFF);
            state_d = HOLD;
          end else if (ho_q == '0) begin
            acc_d = acc_q + ACC_W'(mean) - ACC_W'(bl_q);
          end
        end
        HOLD: begin
          if (pulse_q) begin
            ho_d = HO_W'(HOLDOFF);
          end else begin
            ho_d = ho_q - 1'b1;
            if (ho_q == HO_W'(1))
              state_d = TRACK;
          end
        end
        default: state_d = ACQ;
      endcase
    end
  end

  always_comb begin
    base_d = '0;
    sig_d  = '0;
    bl_out = (byp2_q || state_q == ACQ) ? '0 : DATA_OUTPUT'(bl_q);
    for (int unsigned i = 0; i < LANES; i++) begin
      base_d[i*DATA_OUTPUT +: DATA_OUTPUT] = bl_out;
      sig_d[i*DATA_OUTPUT +: DATA_OUTPUT] =
        DATA_OUTPUT'(signed'(din2_q[i*DATA_WIDTH +: DATA_WIDTH])) - bl_out;
    end
  end

  // S3 estimator update and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACQ;
      acc_q   <= '0;
      cnt_q   <= '0;
      ho_q    <= '0;
      bv_q    <= 1'b0;
      base_q  <= '0;
      sig_q   <= '0;
      pf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ho_q    <= ho_d;
      bv_q    <= vld2_q;
      if (vld2_q) begin
        base_q <= base_d;
        sig_q  <= sig_d;
        pf_q   <= pulse_q;
      end
    end
  end

  assign baseline_valid     = bv_q;
  assign baseline           = base_q;
  assign signal_no_baseline = sig_q;
  assign pulse_flag         = pf_q;
  assign locked             = (state_q != ACQ);

endmodule

// File: tb/tb_baseline_ema_tracker_par.sv
// Scoreboard bench for baseline_ema_tracker_par: a per-block sequential EMA
// model predicts each output block; a monitor compares as outputs appear.
module tb_baseline_ema_tracker_par;
  localparam int DW = 16;
  localparam int L  = 16;
  localparam int DO = 17;
  localparam int K  = 4;
  localparam int HO = 32;
  localparam int LG = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            din_valid = 1'b0;
  logic            bypass = 1'b0;
  logic [DW*L-1:0] din = '0;
  logic [DW-1:0]   thresh = '0;
  logic            baseline_valid, pulse_flag, locked;
  logic [DO*L-1:0] baseline, signal_no_baseline;

  typedef struct packed {
    logic [DO*L-1:0] sig;
    logic [DO-1:0]   base;
    logic            pulse;
    logic            lock;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   ln[L];
  int   m_acc, m_cnt, m_ho;
  bit   m_lock;
  logic [DO*L-1:0] last_sig = '0, last_base = '0;

  always #5 clk = ~clk;

  baseline_ema_tracker_par #(
    .DATA_WIDTH(DW), .LANES(L), .DATA_OUTPUT(DO), .EMA_SHIFT(K), .HOLDOFF(HO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .thresh(thresh),
    .bypass(bypass), .baseline_valid(baseline_valid), .baseline(baseline),
    .signal_no_baseline(signal_no_baseline), .pulse_flag(pulse_flag), .locked(locked)
  );

  task automatic chk(input string nm, input logic [DO*L-1:0] act, input logic [DO*L-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic fill(input int v);
    for (int i = 0; i < L; i++) ln[i] = v;
  endtask

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_ho = 0; m_lock = 1'b0;
  endtask

  // Drives ln[] as one valid block and pushes the model's prediction.
  task automatic send(input bit byp);
    exp_t e;
    int sum, bl, mean, base;
    bit p;
    e = '0; sum = 0; base = 0; p = 1'b0;
    din_valid = 1'b1;
    bypass = byp;
    for (int i = 0; i < L; i++) begin
      din[i*DW +: DW] = DW'(ln[i]);
      sum += ln[i];
    end
    bl = m_acc >>> K;
    mean = sum >>> LG;
    if (!byp) begin
      if (!m_lock) begin
        m_acc += mean;
        m_cnt++;
        if (m_cnt == (1 << K)) m_lock = 1'b1;
      end else begin
        base = bl;
        for (int i = 0; i < L; i++)
          if (ln[i] - bl > int'(thresh)) p = 1'b1;
        if (p) m_ho = HO;
        else if (m_ho > 0) m_ho--;
        else m_acc += mean - bl;
      end
    end
    e.base = DO'(base);
    for (int i = 0; i < L; i++) e.sig[i*DO +: DO] = DO'(ln[i] - base);
    e.pulse = p;
    e.lock = m_lock;
    q.push_back(e);
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      din = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din_valid = 1'b0;
    q.delete();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, (DO*L)'(baseline_valid), '0);
    chk({tag, "_baseline"}, baseline, '0);
    chk({tag, "_signal"}, signal_no_baseline, '0);
    chk({tag, "_pulse"}, (DO*L)'(pulse_flag), '0);
    chk({tag, "_locked"}, (DO*L)'(locked), '0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [DO*L-1:0] rep;
    if (!rst_n) begin
      last_sig = '0;
      last_base = '0;
    end else if (baseline_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=valid required=idle");
      end else begin
        e = q.pop_front();
        rep = '0;
        for (int i = 0; i < L; i++) rep[i*DO +: DO] = e.base;
        chk("baseline", baseline, rep);
        chk("signal", signal_no_baseline, e.sig);
        chk("pulse_flag", (DO*L)'(pulse_flag), (DO*L)'(e.pulse));
        chk("locked", (DO*L)'(locked), (DO*L)'(e.lock));
      end
      last_sig = signal_no_baseline;
      last_base = baseline;
    end else begin
      chk("hold_signal", signal_no_baseline, last_sig);
      chk("hold_baseline", baseline, last_base);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int lat, lvl, thr, v, pl;
    bit found;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // latency with a single bypass block
    fill(5);
    send(1'b1);
    found = 1'b0;
    lat = 0;
    for (int c = 1; c <= 6; c++) begin
      if (!found && baseline_valid) begin
        found = 1'b1;
        lat = c;
      end
      if (!found) begin @(posedge clk); #1; end
    end
    chk("latency", (DO*L)'(lat), (DO*L)'(3));
    @(posedge clk); #1;
    chk("valid_single_cycle", (DO*L)'(baseline_valid), '0);
    drain();

    // acquisition, then pulse gating and holdoff
    thresh = 16'd200;
    fill(1000);
    for (int b = 0; b < 17; b++) send(1'b0);
    ln[7] = 3000;
    send(1'b0);
    fill(1200);
    for (int b = 0; b < 35; b++) send(1'b0);
    drain();

    // valid gaps with a bypass burst mid-acquisition
    do_reset();
    thresh = 16'd200;
    fill(700);
    for (int b = 0; b < 23; b++) begin
      send(b >= 5 && b < 10);
      idle(1);
    end
    drain();

    // extremes
    do_reset();
    fill(-32768);
    for (int b = 0; b < 17; b++) send(1'b0);
    thresh = 16'hFFFF;
    fill(32767);
    send(1'b0);
    send(1'b0);
    drain();

    // randomized traffic
    do_reset();
    thr = int'($urandom_range(50, 1000));
    thresh = DW'(thr);
    lvl = int'($urandom_range(0, 40000)) - 20000;
    for (int b = 0; b < 500; b++) begin
      if ($urandom_range(0, 49) == 0) lvl = int'($urandom_range(0, 40000)) - 20000;
      for (int i = 0; i < L; i++) begin
        v = lvl + int'($urandom_range(0, 60)) - 30;
        ln[i] = clamp16(v);
      end
      if ($urandom_range(0, 7) == 0) begin
        pl = int'($urandom_range(0, L - 1));
        ln[pl] = clamp16(ln[pl] + int'($urandom_range(0, 2 * thr)));
      end
      send($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();

    // mid-stream reset with blocks in flight
    if (!m_lock) begin
      fill(lvl);
      for (int b = 0; b < 16; b++) send(1'b0);
      drain();
    end
    chk("locked_before_reset", (DO*L)'(locked), (DO*L)'(1));
    fill(lvl);
    send(1'b0); send(1'b0); send(1'b0);
    rst_n = 1'b0;
    q.delete();
    model_reset();
    @(negedge clk);
    check_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(6);
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < L; i++) ln[i] = clamp16(lvl + int'($urandom_range(0, 20)) - 10);
      send(1'b0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
